// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and select encodings used by the pipeline muxes.
package cpu_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      SEL_PC4    = 2'd0,
      SEL_BRANCH = 2'd1,
      SEL_JUMP   = 2'd2,
      SEL_JR     = 2'd3
   } pc_sel_e;

   typedef enum logic [1:0] {
      FWD_REG   = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational NUM_IN:1 selector; out-of-range codes give DEFAULT_VAL with an error flag.
module mux_n_sel
   import cpu_pkg::*;
#(
   parameter int unsigned             WIDTH       = DATA_W,
   parameter int unsigned             NUM_IN      = 4,
   parameter int unsigned             SEL_W       = sel_width(NUM_IN),
   parameter logic [WIDTH-1:0]        DEFAULT_VAL = '0
) (
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   output logic [WIDTH-1:0]        sel_val,
   output logic                    sel_err
);

   always_comb begin
      sel_val = DEFAULT_VAL;
      sel_err = 1'b1;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (in_sel == SEL_W'(i)) begin
            sel_val = in_data[i*WIDTH +: WIDTH];
            sel_err = 1'b0;
         end
      end
   end

endmodule

// File: rtl/pipe_mux_n.sv
// Registered NUM_IN-way mux stage with valid/ready handshake and a two-entry skid buffer.
module pipe_mux_n
   import cpu_pkg::*;
#(
   parameter int unsigned             WIDTH       = DATA_W,
   parameter int unsigned             NUM_IN      = 4,
   parameter int unsigned             SEL_W       = sel_width(NUM_IN),
   parameter logic [WIDTH-1:0]        DEFAULT_VAL = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_sel_err,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [WIDTH-1:0] w_sel_val;
   logic             w_sel_err;
   logic             w_in_fire;

   logic             r_main_vld;
   logic [WIDTH-1:0] r_main_data;
   logic             r_main_err;
   logic             r_skid_vld;
   logic [WIDTH-1:0] r_skid_data;
   logic             r_skid_err;

   mux_n_sel #(
      .WIDTH       (WIDTH),
      .NUM_IN      (NUM_IN),
      .SEL_W       (SEL_W),
      .DEFAULT_VAL (DEFAULT_VAL)
   ) u_sel (
      .in_data (in_data),
      .in_sel  (in_sel),
      .sel_val (w_sel_val),
      .sel_err (w_sel_err)
   );

   // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
   assign in_ready    = ~r_skid_vld;
   assign w_in_fire   = in_valid & ~r_skid_vld;
   assign out_valid   = r_main_vld;
   assign out_data    = r_main_data;
   assign out_sel_err = r_main_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_vld  <= 1'b0;
         r_main_data <= '0;
         r_main_err  <= 1'b0;
         r_skid_vld  <= 1'b0;
         r_skid_data <= '0;
         r_skid_err  <= 1'b0;
      end else if (!r_main_vld) begin
         if (w_in_fire) begin
            r_main_vld  <= 1'b1;
            r_main_data <= w_sel_val;
            r_main_err  <= w_sel_err;
         end
      end else if (out_ready) begin
         if (r_skid_vld) begin
            r_main_data <= r_skid_data;
            r_main_err  <= r_skid_err;
            r_skid_vld  <= 1'b0;
         end else if (w_in_fire) begin
            r_main_data <= w_sel_val;
            r_main_err  <= w_sel_err;
         end else begin
            r_main_vld  <= 1'b0;
         end
      end else if (w_in_fire) begin
         r_skid_vld  <= 1'b1;
         r_skid_data <= w_sel_val;
         r_skid_err  <= w_sel_err;
      end
   end

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed-vector and scoreboard bench for pipe_mux_n (4-input and 3-input instances).
module tb_pipe_mux_n;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [127:0] d4_in_data;
   logic [1:0]   d4_in_sel;
   logic         d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready, d4_out_err;
   logic [31:0]  d4_out_data;

   logic [95:0]  d3_in_data;
   logic [1:0]   d3_in_sel;
   logic         d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_out_err;
   logic [31:0]  d3_out_data;

   pipe_mux_n #(.WIDTH(32), .NUM_IN(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(d4_in_data), .in_sel(d4_in_sel),
      .in_valid(d4_in_valid), .in_ready(d4_in_ready), .out_data(d4_out_data),
      .out_sel_err(d4_out_err), .out_valid(d4_out_valid), .out_ready(d4_out_ready)
   );

   pipe_mux_n #(.WIDTH(32), .NUM_IN(3), .DEFAULT_VAL(32'hDEADBEEF)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_sel(d3_in_sel),
      .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
      .out_sel_err(d3_out_err), .out_valid(d3_out_valid), .out_ready(d3_out_ready)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic        vld;
      logic        ordy;
      logic        e_vld;
      logic [31:0] e_data;
      logic        e_ir;
   } vec_t;

   vec_t        tv[13];
   logic [31:0] w[4];
   logic [31:0] q[$];
   logic [1:0]  rs;
   logic        prev_hold;
   int          items_out;
   int          cycles;

   initial begin
      // Rows: inputs applied before an edge, outputs expected just after it.
      tv[0]  = '{2'd0, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b1};
      tv[1]  = '{2'd1, 1'b1, 1'b1, 1'b1, 32'h22222222, 1'b1};
      tv[2]  = '{2'd2, 1'b1, 1'b1, 1'b1, 32'h33333333, 1'b1};
      tv[3]  = '{2'd3, 1'b1, 1'b1, 1'b1, 32'h44444444, 1'b1};
      tv[4]  = '{2'd0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1};
      tv[5]  = '{2'd1, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b1};
      tv[6]  = '{2'd2, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0};
      tv[7]  = '{2'd3, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0};
      tv[8]  = '{2'd0, 1'b0, 1'b1, 1'b1, 32'h33333333, 1'b1};
      tv[9]  = '{2'd0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1};
      tv[10] = '{2'd3, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b1};
      tv[11] = '{2'd0, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b1};
      tv[12] = '{2'd0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1};

      d4_in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      d4_in_sel = 2'd0; d4_in_valid = 1'b0; d4_out_ready = 1'b1;
      d3_in_data = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
      d3_in_sel = 2'd0; d3_in_valid = 1'b0; d3_out_ready = 1'b1;

      // Power-on reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(d4_out_valid), 32'd0);
      chk("rst_out_data", d4_out_data, 32'h0);
      chk("rst_out_err", 32'(d4_out_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(d4_in_ready), 32'd1);

      // Streaming, back-pressure, drop of in_valid while blocked, simultaneous fire
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         d4_in_sel = tv[i].sel; d4_in_valid = tv[i].vld; d4_out_ready = tv[i].ordy;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_valid", i), 32'(d4_out_valid), 32'(tv[i].e_vld));
         chk($sformatf("vec%0d_in_ready", i), 32'(d4_in_ready), 32'(tv[i].e_ir));
         if (tv[i].e_vld) begin
            chk($sformatf("vec%0d_data", i), d4_out_data, tv[i].e_data);
            chk($sformatf("vec%0d_err", i), 32'(d4_out_err), 32'd0);
         end
      end

      // Out-of-range select on the 3-input instance
      @(negedge clk); d3_in_sel = 2'd3; d3_in_valid = 1'b1;
      @(negedge clk); d3_in_sel = 2'd0;
      chk("oor_valid", 32'(d3_out_valid), 32'd1);
      chk("oor_data", d3_out_data, 32'hDEADBEEF);
      chk("oor_err", 32'(d3_out_err), 32'd1);
      @(negedge clk); d3_in_sel = 2'd2;
      chk("inr0_data", d3_out_data, 32'hAAAAAAAA);
      chk("inr0_err", 32'(d3_out_err), 32'd0);
      @(negedge clk); d3_in_valid = 1'b0;
      chk("inr2_data", d3_out_data, 32'hCCCCCCCC);
      chk("inr2_err", 32'(d3_out_err), 32'd0);

      // Async reset with main and skid both full
      @(negedge clk); d4_in_sel = 2'd1; d4_in_valid = 1'b1; d4_out_ready = 1'b0;
      @(negedge clk); d4_in_sel = 2'd2;
      @(negedge clk); d4_in_valid = 1'b0;
      chk("full_in_ready", 32'(d4_in_ready), 32'd0);
      chk("full_valid", 32'(d4_out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(d4_out_valid), 32'd0);
      chk("arst_data", d4_out_data, 32'h0);
      chk("arst_err", 32'(d4_out_err), 32'd0);
      @(negedge clk); rst_n = 1'b1; d4_out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(d4_in_ready), 32'd1);
      chk("post_rst_valid", 32'(d4_out_valid), 32'd0);

      // Random handshake against a FIFO scoreboard
      prev_hold = 1'b0; items_out = 0; cycles = 0;
      while (items_out < 10000 && cycles < 60000 && n_err < 20) begin
         @(negedge clk);
         cycles++;
         if (prev_hold) chk("hold_valid", 32'(d4_out_valid), 32'd1);
         if (d4_out_valid) begin
            if (q.size() == 0) chk("rand_spurious", 32'd1, 32'd0);
            else begin
               chk("rand_data", d4_out_data, q[0]);
               chk("rand_err", 32'(d4_out_err), 32'd0);
            end
         end
         d4_out_ready = ($urandom_range(0, 3) != 0);
         if (d4_out_valid && d4_out_ready && q.size() != 0) begin
            void'(q.pop_front());
            items_out++;
         end
         prev_hold = d4_out_valid && !d4_out_ready;
         for (int k = 0; k < 4; k++) w[k] = $urandom;
         rs = 2'($urandom_range(0, 3));
         d4_in_data = {w[3], w[2], w[1], w[0]};
         d4_in_sel = rs;
         d4_in_valid = ($urandom_range(0, 3) != 0);
         if (d4_in_valid && d4_in_ready) q.push_back(w[rs]);
      end
      chk("rand_items_delivered", 32'(items_out), 32'd10000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
